// File: rtl/imu_spi_reader_if.sv
// IMU SPI pins plus the parallel sample bus; master = reader, slave = device/downstream side.
// Purely wires, no latency; the sample bus has no backpressure (valid strobe, data held until the next one).
interface imu_spi_reader_if;
  logic        imu_cs;
  logic        imu_clk;
  logic        imu_mosi;
  logic        imu_miso;
  logic        sample_valid;
  logic [15:0] ax;
  logic [15:0] ay;
  logic [15:0] az;
  logic [15:0] temp;
  logic [15:0] gx;
  logic [15:0] gy;
  logic [15:0] gz;

  modport master (
    output imu_cs, imu_clk, imu_mosi,
    input  imu_miso,
    output sample_valid, ax, ay, az, temp, gx, gy, gz
  );

  modport slave (
    input  imu_cs, imu_clk, imu_mosi,
    output imu_miso,
    input  sample_valid, ax, ay, az, temp, gx, gy, gz
  );
endinterface

// File: rtl/imu_spi_reader.sv
// Mode-3 SPI burst reader: each IMU interrupt edge reads 14 bytes from START_ADDR into one parallel sample.
// Edge-to-strobe about 4+243*CLK_DIV cycles; no backpressure, edges arriving while busy are dropped and counted.
module imu_spi_reader #(
  parameter int         CLK_DIV    = 25,
  parameter logic [6:0] START_ADDR = 7'h3B,
  parameter int         NUM_BYTES  = 14
) (
  input  logic                    sys_clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    imu_int,
  output logic                    busy,
  output logic [7:0]              missed_count,
  imu_spi_reader_if.master        bus
);

  localparam int NBITS = 8 + 8 * NUM_BYTES;
  localparam int DBITS = 8 * NUM_BYTES;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(NBITS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP,
    DONE
  } state_t;

  state_t             state;
  logic [2:0]         int_sync;
  logic [DIV_W-1:0]   div;
  logic [IDX_W-1:0]   bit_idx;
  logic [DBITS-1:0]   shift_reg;

  logic               int_edge;
  logic               div_done;
  logic               last_bit;
  logic [IDX_W-1:0]   next_idx;
  logic [7:0]         cmd_byte;
  logic               next_mosi;

  assign int_edge = int_sync[1] & ~int_sync[2];
  assign div_done = (div == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_idx == IDX_W'(NBITS - 1));
  assign next_idx = bit_idx + IDX_W'(1);
  assign cmd_byte = {1'b1, START_ADDR};

  // Command bits go out first; every data-phase bit is a don't-care driven as 0.
  always_comb begin
    next_mosi = 1'b0;
    if (next_idx < IDX_W'(8))
      next_mosi = cmd_byte[3'd7 - next_idx[2:0]];
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      state            <= IDLE;
      int_sync         <= '0;
      div              <= '0;
      bit_idx          <= '0;
      shift_reg        <= '0;
      busy             <= 1'b0;
      missed_count     <= '0;
      bus.imu_cs       <= 1'b1;
      bus.imu_clk      <= 1'b1;
      bus.imu_mosi     <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.ax           <= '0;
      bus.ay           <= '0;
      bus.az           <= '0;
      bus.temp         <= '0;
      bus.gx           <= '0;
      bus.gy           <= '0;
      bus.gz           <= '0;
    end else begin
      int_sync         <= {int_sync[1:0], imu_int};
      bus.sample_valid <= 1'b0;

      // DONE still counts as busy, so an edge coinciding with the strobe is a miss.
      if (int_edge && state != IDLE && missed_count != 8'hFF)
        missed_count <= missed_count + 8'd1;

      case (state)
        IDLE: begin
          if (int_edge && enable) begin
            state      <= SETUP;
            busy       <= 1'b1;
            bus.imu_cs <= 1'b0;
            div        <= '0;
          end
        end

        SETUP: begin
          if (div_done) begin
            div          <= '0;
            bit_idx      <= '0;
            bus.imu_clk  <= 1'b0;
            bus.imu_mosi <= cmd_byte[7];
            state        <= SHIFT_LO;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        SHIFT_LO: begin
          if (div_done) begin
            div         <= '0;
            bus.imu_clk <= 1'b1;
            state       <= SHIFT_HI;
            if (bit_idx >= IDX_W'(8))
              shift_reg <= {shift_reg[DBITS-2:0], bus.imu_miso};
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        SHIFT_HI: begin
          if (div_done) begin
            div <= '0;
            if (last_bit) begin
              state <= HOLD;
            end else begin
              bit_idx      <= next_idx;
              bus.imu_clk  <= 1'b0;
              bus.imu_mosi <= next_mosi;
              state        <= SHIFT_LO;
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        HOLD: begin
          if (div_done) begin
            div          <= '0;
            bus.imu_cs   <= 1'b1;
            bus.imu_mosi <= 1'b0;
            state        <= GAP;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        GAP: begin
          if (div_done) begin
            div   <= '0;
            state <= DONE;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        DONE: begin
          bus.ax           <= shift_reg[DBITS-1  -: 16];
          bus.ay           <= shift_reg[DBITS-17 -: 16];
          bus.az           <= shift_reg[DBITS-33 -: 16];
          bus.temp         <= shift_reg[DBITS-49 -: 16];
          bus.gx           <= shift_reg[DBITS-65 -: 16];
          bus.gy           <= shift_reg[DBITS-81 -: 16];
          bus.gz           <= shift_reg[DBITS-97 -: 16];
          bus.sample_valid <= 1'b1;
          busy             <= 1'b0;
          state            <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_spi_reader.sv
// Bench for imu_spi_reader: random IMU register contents served by a behavioural SPI slave,
// expected samples built directly from the byte layout.
module tb_imu_spi_reader;

  localparam int CD  = 4;
  localparam int NB  = 14;
  localparam int LAT = 4 + 243 * CD;

  logic       sys_clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       imu_int;
  logic       busy;
  logic [7:0] missed_count;

  imu_spi_reader_if bus ();

  imu_spi_reader #(
    .CLK_DIV    (CD),
    .START_ADDR (7'h3B),
    .NUM_BYTES  (NB)
  ) dut (
    .sys_clk      (sys_clk),
    .resetn       (resetn),
    .enable       (enable),
    .imu_int      (imu_int),
    .busy         (busy),
    .missed_count (missed_count),
    .bus          (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int missed_exp = 0;
  logic [7:0] slave_bytes [NB];

  // SPI slave state (written only by the slave process)
  int         rise_now = 0;
  int         fall_now = 0;
  int         last_rises = 0;
  int         data_ones = 0;
  logic [7:0] cmd_cap = 8'h00;

  // sys_clk monitor state (written only by the monitor process)
  int valid_cnt = 0;
  int cs_run = 0;
  int last_cs_width = 0;
  int cs_fall_cnt = 0;

  // Mode-3 slave: drive MISO on falling SCK, capture MOSI on rising SCK.
  initial begin
    logic       pc;
    logic       pcs;
    logic [7:0] b;
    int         k;
    pc  = 1'b1;
    pcs = 1'b1;
    bus.imu_miso = 1'b0;
    forever begin
      @(bus.imu_cs or bus.imu_clk);
      if (pcs === 1'b1 && bus.imu_cs === 1'b0) begin
        rise_now  = 0;
        fall_now  = 0;
        cmd_cap   = 8'h00;
        data_ones = 0;
      end else if (pcs === 1'b0 && bus.imu_cs === 1'b1) begin
        last_rises = rise_now;
      end else if (bus.imu_cs === 1'b0) begin
        if (pc === 1'b1 && bus.imu_clk === 1'b0) begin
          bus.imu_miso = 1'b0;
          if (fall_now >= 8 && fall_now < 8 + 8 * NB) begin
            k = fall_now - 8;
            b = slave_bytes[k / 8];
            bus.imu_miso = b[7 - (k % 8)];
          end
          fall_now++;
        end else if (pc === 1'b0 && bus.imu_clk === 1'b1) begin
          if (rise_now < 8) cmd_cap = {cmd_cap[6:0], bus.imu_mosi};
          else if (bus.imu_mosi === 1'b1) data_ones++;
          rise_now++;
        end
      end
      pc  = bus.imu_clk;
      pcs = bus.imu_cs;
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (bus.sample_valid === 1'b1) valid_cnt++;
      if (bus.imu_cs === 1'b0) begin
        cs_run++;
        if (cs_run == 1) cs_fall_cnt++;
      end else if (cs_run != 0) begin
        last_cs_width = cs_run;
        cs_run = 0;
      end
    end
  end

  function automatic logic [15:0] exp_word(input int i);
    return {slave_bytes[2*i], slave_bytes[2*i+1]};
  endfunction

  function automatic logic [15:0] dut_word(input int i);
    case (i)
      0:       return bus.ax;
      1:       return bus.ay;
      2:       return bus.az;
      3:       return bus.temp;
      4:       return bus.gx;
      5:       return bus.gy;
      default: return bus.gz;
    endcase
  endfunction

  task automatic load_random;
    for (int i = 0; i < NB; i++) slave_bytes[i] = 8'($urandom);
  endtask

  task automatic pulse_int;
    @(negedge sys_clk);
    imu_int = 1'b1;
    repeat (3) @(negedge sys_clk);
    imu_int = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3 * LAT && !ok; c++) begin
      @(negedge sys_clk);
      if (bus.sample_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    resetn  = 1'b0;
    enable  = 1'b0;
    imu_int = 1'b0;
    repeat (5) @(negedge sys_clk);
    total++; if (bus.imu_cs !== 1'b1) begin bad++; $display("FAIL reset_cs got=%b want=1", bus.imu_cs); end
    total++; if (bus.imu_clk !== 1'b1) begin bad++; $display("FAIL reset_clk got=%b want=1", bus.imu_clk); end
    total++; if (bus.imu_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", bus.imu_mosi); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (bus.sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.sample_valid); end
    total++; if (missed_count !== 8'd0) begin bad++; $display("FAIL reset_missed got=%0d want=0", missed_count); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (dut_word(i) !== 16'h0000) begin bad++; $display("FAIL reset_word%0d got=%h want=0000", i, dut_word(i)); end
    end
    resetn = 1'b1;
    missed_exp = 0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_single_burst;
    int lat;
    int vb;
    bit got;
    bit busy_seen;
    load_random();
    enable = 1'b1;
    vb = valid_cnt;
    lat = 0;
    got = 1'b0;
    busy_seen = 1'b0;
    @(negedge sys_clk);
    imu_int = 1'b1;
    for (int c = 0; c < 3 * LAT && !got; c++) begin
      @(negedge sys_clk);
      lat++;
      if (lat == 3) imu_int = 1'b0;
      if (lat == 10 && busy === 1'b1) busy_seen = 1'b1;
      if (bus.sample_valid === 1'b1) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL single_timeout got=none want=sample_valid"); end
    total++; if (lat < LAT - 2 || lat > LAT + 2) begin bad++; $display("FAIL single_latency got=%0d want=%0d+-2", lat, LAT); end
    total++; if (!busy_seen) begin bad++; $display("FAIL single_busy got=0 want=1"); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (dut_word(i) !== exp_word(i)) begin bad++; $display("FAIL single_word%0d got=%h want=%h", i, dut_word(i), exp_word(i)); end
    end
    total++; if (cmd_cap !== 8'hBB) begin bad++; $display("FAIL single_cmd got=%h want=bb", cmd_cap); end
    total++; if (data_ones != 0) begin bad++; $display("FAIL single_mosi_data got=%0d ones want=0", data_ones); end
    @(negedge sys_clk);
    total++; if (bus.sample_valid !== 1'b0) begin bad++; $display("FAIL single_strobe_width got=%b want=0", bus.sample_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
    total++; if (valid_cnt - vb != 1) begin bad++; $display("FAIL single_valid_count got=%0d want=1", valid_cnt - vb); end
  endtask

  task automatic test_second_burst;
    bit ok;
    load_random();
    pulse_int();
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL second_timeout got=none want=sample_valid"); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (dut_word(i) !== exp_word(i)) begin bad++; $display("FAIL second_word%0d got=%h want=%h", i, dut_word(i), exp_word(i)); end
    end
    total++; if (last_cs_width != 242 * CD) begin bad++; $display("FAIL second_cs_width got=%0d want=%0d", last_cs_width, 242 * CD); end
    total++; if (last_rises != 8 + 8 * NB) begin bad++; $display("FAIL second_sck_rises got=%0d want=%0d", last_rises, 8 + 8 * NB); end
    repeat (20) @(negedge sys_clk);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (dut_word(i) !== exp_word(i)) begin bad++; $display("FAIL second_hold%0d got=%h want=%h", i, dut_word(i), exp_word(i)); end
    end
  endtask

  task automatic test_enable_off;
    int fb;
    bit ok;
    enable = 1'b0;
    fb = cs_fall_cnt;
    pulse_int();
    repeat (30) @(negedge sys_clk);
    total++; if (cs_fall_cnt != fb) begin bad++; $display("FAIL disabled_cs got=%0d falls want=0", cs_fall_cnt - fb); end
    total++; if (missed_count !== 8'(missed_exp)) begin bad++; $display("FAIL disabled_missed got=%0d want=%0d", missed_count, missed_exp); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL disabled_busy got=%b want=0", busy); end
    enable = 1'b1;
    load_random();
    pulse_int();
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL reenable_timeout got=none want=sample_valid"); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (dut_word(i) !== exp_word(i)) begin bad++; $display("FAIL reenable_word%0d got=%h want=%h", i, dut_word(i), exp_word(i)); end
    end
  endtask

  task automatic test_missed;
    int vb;
    bit ok;
    load_random();
    vb = valid_cnt;
    pulse_int();
    enable = 1'b0;  // dropping enable mid-burst must not abort it
    repeat (3) pulse_int();
    missed_exp = (missed_exp + 3 > 255) ? 255 : missed_exp + 3;
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL missed_timeout got=none want=sample_valid"); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (dut_word(i) !== exp_word(i)) begin bad++; $display("FAIL missed_word%0d got=%h want=%h", i, dut_word(i), exp_word(i)); end
    end
    @(negedge sys_clk);
    total++; if (missed_count !== 8'(missed_exp)) begin bad++; $display("FAIL missed_count got=%0d want=%0d", missed_count, missed_exp); end
    total++; if (valid_cnt - vb != 1) begin bad++; $display("FAIL missed_valid_count got=%0d want=1", valid_cnt - vb); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_burst;
    int vb;
    int c;
    bit hit;
    bit ok;
    load_random();
    vb = valid_cnt;
    hit = 1'b0;
    @(negedge sys_clk);
    imu_int = 1'b1;
    c = 0;
    while (c < 3 * LAT && !hit) begin
      @(negedge sys_clk);
      c++;
      if (c == 3) imu_int = 1'b0;
      if (bus.imu_cs === 1'b0 && rise_now == 50) hit = 1'b1;
    end
    imu_int = 1'b0;
    total++; if (!hit) begin bad++; $display("FAIL midreset_reach got=%0d edges want=50", rise_now); end
    resetn = 1'b0;
    @(posedge sys_clk);
    #1;
    total++; if (bus.imu_cs !== 1'b1) begin bad++; $display("FAIL midreset_cs got=%b want=1", bus.imu_cs); end
    total++; if (bus.imu_clk !== 1'b1) begin bad++; $display("FAIL midreset_clk got=%b want=1", bus.imu_clk); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (bus.ax !== 16'h0000) begin bad++; $display("FAIL midreset_ax got=%h want=0000", bus.ax); end
    @(negedge sys_clk);
    resetn = 1'b1;
    missed_exp = 0;
    repeat (50) @(negedge sys_clk);
    total++; if (valid_cnt != vb) begin bad++; $display("FAIL midreset_no_valid got=%0d want=0", valid_cnt - vb); end
    total++; if (missed_count !== 8'd0) begin bad++; $display("FAIL midreset_missed got=%0d want=0", missed_count); end
    load_random();
    pulse_int();
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL postreset_timeout got=none want=sample_valid"); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (dut_word(i) !== exp_word(i)) begin bad++; $display("FAIL postreset_word%0d got=%h want=%h", i, dut_word(i), exp_word(i)); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    for (int n = 0; n < 3; n++) begin
      load_random();
      pulse_int();
      wait_valid(ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b%0d_timeout got=none want=sample_valid", n); end
      for (int i = 0; i < 7; i++) begin
        total++;
        if (dut_word(i) !== exp_word(i)) begin bad++; $display("FAIL b2b%0d_word%0d got=%h want=%h", n, i, dut_word(i), exp_word(i)); end
      end
      repeat ($urandom_range(0, 4)) @(negedge sys_clk);
    end
    total++; if (missed_count !== 8'(missed_exp)) begin bad++; $display("FAIL b2b_missed got=%0d want=%0d", missed_count, missed_exp); end
  endtask

  task automatic test_saturation;
    int fb;
    int dropped;
    bit idle;
    bit ok;
    enable = 1'b1;
    fb = cs_fall_cnt;
    for (int n = 0; n < 300; n++) pulse_int();
    idle = 1'b0;
    for (int c = 0; c < 2 * LAT && !idle; c++) begin
      @(negedge sys_clk);
      if (busy === 1'b0) idle = 1'b1;
    end
    total++; if (!idle) begin bad++; $display("FAIL sat_idle got=busy want=idle"); end
    dropped = 300 - (cs_fall_cnt - fb);
    missed_exp = (missed_exp + dropped > 255) ? 255 : missed_exp + dropped;
    total++; if (missed_count !== 8'(missed_exp)) begin bad++; $display("FAIL sat_count got=%0d want=%0d", missed_count, missed_exp); end
    load_random();
    pulse_int();
    pulse_int();
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_burst_timeout got=none want=sample_valid"); end
    @(negedge sys_clk);
    total++; if (missed_count !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", missed_count); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (dut_word(i) !== exp_word(i)) begin bad++; $display("FAIL sat_word%0d got=%h want=%h", i, dut_word(i), exp_word(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_second_burst();
    test_enable_off();
    test_missed();
    test_reset_mid_burst();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
